// File: rtl/pwm_capture.sv
// Gate-signal capture: recovers on-time, period and phase-to-carrier-sync of a PWM input
// in clock counts, flagging a stuck input when no rising edge arrives within TIMEOUT cycles.
module pwm_capture #(
  parameter int W       = 11,
  parameter int DT_COMP = 0,
  parameter int TIMEOUT = 2047
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pwm_in,
  input  logic         sync_in,
  output logic [W-1:0] duty_meas,
  output logic [W-1:0] period_meas,
  output logic [W-1:0] angle_meas,
  output logic         angle_ok,
  output logic         meas_valid,
  output logic         stuck
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] TO  = W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t       state, state_nxt;
  logic         s1, s2, s3;
  logic         sy1, sy2;
  logic [W-1:0] per_cnt, per_nxt;
  logic [W-1:0] hi_cnt, hi_nxt;
  logic [W-1:0] ph_cnt, ph_nxt;
  logic         ph_seen, seen_nxt;
  logic         rise, capture, timeout;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] x);
    return (x == MAX) ? x : x + 1'b1;
  endfunction

  function automatic logic [W-1:0] dt_comp_sat(input logic [W-1:0] x);
    logic [31:0] s;
    s = 32'(x) + 32'(DT_COMP);
    return (s > 32'(MAX)) ? MAX : s[W-1:0];
  endfunction

  // Front end: pwm synchronizer and the matching sync pipe; ph_cnt is the sync path's
  // third stage, so a sync and a pwm edge sampled on the same clock give angle 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      s3  <= 1'b0;
      sy1 <= 1'b0;
      sy2 <= 1'b0;
    end else begin
      s1  <= pwm_in;
      s2  <= s1;
      s3  <= s2;
      sy1 <= sync_in;
      sy2 <= sy1;
    end
  end

  assign rise     = s2 & ~s3;
  assign ph_nxt   = sy2 ? '0 : sat_inc(ph_cnt);
  assign seen_nxt = ph_seen | sy2;

  always_comb begin
    state_nxt = state;
    per_nxt   = per_cnt;
    hi_nxt    = hi_cnt;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HIGH;
          per_nxt   = W'(1);
          hi_nxt    = W'(1);
        end
      end
      HIGH, LOW: begin
        per_nxt = sat_inc(per_cnt);
        hi_nxt  = s2 ? sat_inc(hi_cnt) : hi_cnt;
        if (state == LOW && rise) begin
          capture   = 1'b1;
          state_nxt = HIGH;
          per_nxt   = W'(1);
          hi_nxt    = W'(1);
        end else if (per_cnt == TO) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else if (state == HIGH && !s2) begin
          state_nxt = LOW;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter / FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      ph_cnt  <= '0;
      ph_seen <= 1'b0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      hi_cnt  <= hi_nxt;
      ph_cnt  <= ph_nxt;
      ph_seen <= seen_nxt;
    end
  end

  // Result registers, updated one cycle after the closing rising edge
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_meas   <= '0;
      period_meas <= '0;
      angle_meas  <= '0;
      angle_ok    <= 1'b0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      meas_valid <= capture;
      if (capture) begin
        period_meas <= per_cnt;
        duty_meas   <= dt_comp_sat(hi_cnt);
        angle_meas  <= ph_nxt;
        angle_ok    <= seen_nxt;
        stuck       <= 1'b0;
      end else if (timeout) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: two instances (DT_COMP=0/TIMEOUT=500 and
// DT_COMP=4/TIMEOUT=2047) driven by the same pwm/sync stimulus.
module tb_pwm_capture;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic         sync_in = 1'b0;
  logic [W-1:0] duty0, period0, angle0, duty4, period4, angle4;
  logic         ok0, mv0, stuck0, ok4, mv4, stuck4;

  int checks = 0;
  int errors = 0;
  int n0 = 0;
  int n4 = 0;

  always #5 clk = ~clk;

  pwm_capture #(.W(W), .DT_COMP(0), .TIMEOUT(500)) u_dut0 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .sync_in(sync_in),
    .duty_meas(duty0), .period_meas(period0), .angle_meas(angle0),
    .angle_ok(ok0), .meas_valid(mv0), .stuck(stuck0)
  );

  pwm_capture #(.W(W), .DT_COMP(4), .TIMEOUT(2047)) u_dut4 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .sync_in(sync_in),
    .duty_meas(duty4), .period_meas(period4), .angle_meas(angle4),
    .angle_ok(ok4), .meas_valid(mv4), .stuck(stuck4)
  );

  always @(negedge clk) begin
    if (mv0) n0++;
    if (mv4) n4++;
  end

  typedef struct {
    int hi;
    int lo;
    int lead;
    int duty;
    int period;
    int angle;
    int ok;
    int duty4;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    pwm_in  = 1'b0;
    sync_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  // One pwm period starting with its rising edge; optional sync pulse lead cycles before the next rise
  task automatic pulse(input int hi, input int lo, input int lead);
    for (int i = 0; i < hi + lo; i++) begin
      pwm_in  = (i < hi);
      sync_in = (lead > 0) && (i == hi + lo - lead);
      tick();
    end
    sync_in = 1'b0;
  endtask

  initial begin
    int b0, b4;
    //          hi   lo  lead duty per  ang ok duty4
    vecs[0] = '{50,  150, 30,  50, 200, 30, 1, 54};
    vecs[1] = '{50,  150, 0,   50, 200, -1, 0, 54};
    vecs[2] = '{10,  90,  5,   10, 100, 5,  1, 14};
    vecs[3] = '{1,   9,   9,   1,  10,  9,  1, 5};
    vecs[4] = '{99,  1,   1,   99, 100, 1,  1, 103};
    vecs[5] = '{120, 130, 130, 120, 250, 130, 1, 124};
    vecs[6] = '{40,  60,  100, 40, 100, 0,  1, 44};

    do_reset();
    chk("reset duty", int'(duty0), 0);
    chk("reset period", int'(period0), 0);
    chk("reset angle", int'(angle0), 0);
    chk("reset angle_ok", int'(ok0), 0);
    chk("reset meas_valid", int'(mv0), 0);
    chk("reset stuck", int'(stuck0), 0);

    foreach (vecs[k]) begin
      do_reset();
      b0 = n0;
      b4 = n4;
      repeat (3) pulse(vecs[k].hi, vecs[k].lo, vecs[k].lead);
      chk($sformatf("v%0d valid count", k), n0 - b0, 2);
      chk($sformatf("v%0d duty", k), int'(duty0), vecs[k].duty);
      chk($sformatf("v%0d period", k), int'(period0), vecs[k].period);
      if (vecs[k].angle >= 0) chk($sformatf("v%0d angle", k), int'(angle0), vecs[k].angle);
      chk($sformatf("v%0d angle_ok", k), int'(ok0), vecs[k].ok);
      chk($sformatf("v%0d stuck", k), int'(stuck0), 0);
      chk($sformatf("v%0d dt duty", k), int'(duty4), vecs[k].duty4);
      chk($sformatf("v%0d dt valid count", k), n4 - b4, 2);
    end

    // Deadtime compensation saturates at 2**W-1
    do_reset();
    b4 = n4;
    repeat (2) pulse(2045, 1, 0);
    chk("sat valid count", n4 - b4, 1);
    chk("sat duty", int'(duty4), 2047);
    chk("sat period", int'(period4), 2046);

    // Stuck high after three good periods, then recovery
    do_reset();
    b0 = n0;
    repeat (3) pulse(50, 150, 30);
    pwm_in = 1'b1;
    repeat (450) tick();
    chk("stuck early", int'(stuck0), 0);
    repeat (100) tick();
    chk("stuck high", int'(stuck0), 1);
    chk("stuck hold duty", int'(duty0), 50);
    chk("stuck hold period", int'(period0), 200);
    chk("stuck valid count", n0 - b0, 3);
    pwm_in = 1'b0;
    repeat (150) tick();
    b0 = n0;
    pulse(60, 140, 0);
    chk("resume first rise no valid", n0 - b0, 0);
    chk("resume stuck kept", int'(stuck0), 1);
    pulse(60, 140, 0);
    chk("resume valid", n0 - b0, 1);
    chk("resume stuck clear", int'(stuck0), 0);
    chk("resume duty", int'(duty0), 60);
    chk("resume period", int'(period0), 200);
    repeat (350) tick();
    chk("stuck low", int'(stuck0), 1);
    chk("stuck low hold duty", int'(duty0), 60);

    // Reset in the middle of a low phase
    do_reset();
    repeat (2) pulse(50, 150, 30);
    pwm_in = 1'b1;
    repeat (50) tick();
    pwm_in = 1'b0;
    repeat (70) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst duty", int'(duty0), 0);
    chk("midrst period", int'(period0), 0);
    chk("midrst angle_ok", int'(ok0), 0);
    chk("midrst valid", int'(mv0), 0);
    repeat (80) tick();
    b0 = n0;
    pulse(50, 150, 30);
    chk("midrst first rise no valid", n0 - b0, 0);
    pulse(50, 150, 30);
    chk("midrst second rise valid", n0 - b0, 1);
    chk("midrst duty after", int'(duty0), 50);
    chk("midrst period after", int'(period0), 200);
    chk("midrst angle after", int'(angle0), 30);
    chk("midrst angle_ok after", int'(ok0), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
